// File: rtl/mcu_mem_pkg.sv
// ---------------------------------------------------------------------------
// mcu_mem_pkg
// Shared types and defaults for the MCU program/data RAM initiator.
//   ADDR_W_DEF / DATA_W_DEF : default RAM geometry (4K x 16)
//   STARVE_W                : width of the fetch anti-starvation counter
//   prio_e                  : arbitration priority state
//   resp_sel_e              : which requester owns next cycle's read data
// ---------------------------------------------------------------------------
package mcu_mem_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 16;
  localparam int STARVE_W   = 4;   // holds STARVE_MAX up to 15

  typedef enum logic {
    PRIO_D,
    PRIO_IF
  } prio_e;

  typedef enum logic [1:0] {
    RSP_NONE,
    RSP_IF,
    RSP_D
  } resp_sel_e;

endpackage

// File: rtl/mcu_ram_arb.sv
// ---------------------------------------------------------------------------
// mcu_ram_arb
// Two-requester arbiter for the single RAM port. Data accesses normally win;
// once fetch has been denied STARVE_MAX cycles in a row, fetch gets priority
// until it is granted once.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   if_req_i / d_req_i  fetch / data requests (held until granted)
//   if_gnt_o / d_gnt_o  combinational one-hot grants for this cycle
// ---------------------------------------------------------------------------
module mcu_ram_arb
  import mcu_mem_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic if_req_i,
  input  logic d_req_i,
  output logic if_gnt_o,
  output logic d_gnt_o
);

  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  prio_e               prio_q, prio_d;
  logic [STARVE_W-1:0] starve_q, starve_d;

  // NOTE: every output of a combinational block gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    if_gnt_o = 1'b0;
    d_gnt_o  = 1'b0;
    starve_d = '0;
    prio_d   = prio_q;

    if (prio_q == PRIO_IF && if_req_i) begin
      if_gnt_o = 1'b1;
    end else if (d_req_i) begin
      d_gnt_o = 1'b1;
    end else if (if_req_i) begin
      if_gnt_o = 1'b1;
    end

    // Count cycles in which fetch is waiting but loses; saturate at the limit.
    if (if_req_i && !if_gnt_o) begin
      starve_d = (starve_q == STARVE_LIM) ? starve_q : starve_q + 1'b1;
    end

    // Switching on the next-state count lets fetch win on the cycle right
    // after its STARVE_MAX-th denial rather than one cycle later.
    case (prio_q)
      PRIO_D:  if (starve_d == STARVE_LIM) prio_d = PRIO_IF;
      PRIO_IF: if (if_gnt_o) prio_d = PRIO_D;
      default: prio_d = PRIO_D;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio_q   <= PRIO_D;
      starve_q <= '0;
    end else begin
      prio_q   <= prio_d;
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/mcu_ram_master.sv
// ---------------------------------------------------------------------------
// mcu_ram_master
// Initiator for the MCU 4K x 16 single-port RAM (1-cycle registered read).
// Muxes the instruction-fetch and data requesters onto the RAM port and routes
// read data back with a one-cycle rvalid strobe on the granted port.
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   if_req/if_addr -> if_gnt        fetch request / address / grant
//   if_rvalid/if_rdata              fetch response (cycle after grant)
//   d_req/d_we/d_addr/d_wdata       data request (write when d_we=1)
//   d_gnt, d_rvalid/d_rdata         data grant and read response
//   ram_ce/ram_wre/ram_ad/ram_din   RAM command side
//   ram_oce, ram_reset              RAM output-register enable / reset
//   ram_dout                        RAM read data
// ---------------------------------------------------------------------------
module mcu_ram_master
  import mcu_mem_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              ram_ce,
  output logic              ram_oce,
  output logic              ram_reset,
  output logic              ram_wre,
  output logic [ADDR_W-1:0] ram_ad,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  logic [ADDR_W-1:0] ad_q, ad_d;
  logic [DATA_W-1:0] din_q, din_d;
  resp_sel_e         resp_sel_q, resp_sel_d;

  mcu_ram_arb #(
    .STARVE_MAX (STARVE_MAX)
  ) u_arb (
    .clk      (clk),
    .reset    (reset),
    .if_req_i (if_req),
    .d_req_i  (d_req),
    .if_gnt_o (if_gnt),
    .d_gnt_o  (d_gnt)
  );

  // Address and write data keep their last driven value when idle, so the
  // RAM pins only toggle on real accesses.
  always_comb begin
    ad_d       = ad_q;
    din_d      = din_q;
    resp_sel_d = RSP_NONE;
    if (d_gnt) begin
      ad_d = d_addr;
      if (d_we) din_d      = d_wdata;
      else      resp_sel_d = RSP_D;
    end else if (if_gnt) begin
      ad_d       = if_addr;
      resp_sel_d = RSP_IF;
    end
  end

  // Clearing resp_sel on reset drops any read still in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ad_q       <= '0;
      din_q      <= '0;
      resp_sel_q <= RSP_NONE;
    end else begin
      ad_q       <= ad_d;
      din_q      <= din_d;
      resp_sel_q <= resp_sel_d;
    end
  end

  assign ram_ce    = if_gnt | d_gnt;
  assign ram_wre   = d_gnt & d_we;
  assign ram_ad    = ad_d;
  assign ram_din   = din_d;
  assign ram_oce   = 1'b1;
  assign ram_reset = reset;

  // The RAM output register already holds the data; pass it straight through.
  assign if_rvalid = (resp_sel_q == RSP_IF);
  assign d_rvalid  = (resp_sel_q == RSP_D);
  assign if_rdata  = ram_dout;
  assign d_rdata   = ram_dout;

endmodule

// File: tb/tb_mcu_ram_master.sv
// ---------------------------------------------------------------------------
// tb_mcu_ram_master
// Directed bench for mcu_ram_master with a behavioural 4K x 16 RAM. Stimulus
// pushes expected read responses into per-port queues; a negedge monitor pops
// and compares whenever a response is due or an rvalid strobe appears.
// ---------------------------------------------------------------------------
module tb_mcu_ram_master;

  localparam int AW = 12;
  localparam int DW = 16;

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          ram_ce;
  logic          ram_oce;
  logic          ram_reset;
  logic          ram_wre;
  logic [AW-1:0] ram_ad;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t if_q[$];
  exp_t d_q[$];

  always #5 clk = ~clk;

  mcu_ram_master #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .STARVE_MAX (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .ram_ce    (ram_ce),
    .ram_oce   (ram_oce),
    .ram_reset (ram_reset),
    .ram_wre   (ram_wre),
    .ram_ad    (ram_ad),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout)
  );

  // Behavioural single-port RAM: registered read, write does not update dout.
  logic [DW-1:0] mem [0:4095];
  always @(posedge clk or posedge ram_reset) begin
    if (ram_reset) begin
      ram_dout <= '0;
    end else if (ram_ce) begin
      if (ram_wre) mem[ram_ad] <= ram_din;
      else         ram_dout    <= mem[ram_ad];
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor.
  always @(negedge clk) begin
    if (!reset) begin
      if (if_q.size() != 0 && if_q[0].due == cyc) begin
        exp_t e;
        e = if_q.pop_front();
        check("if_rvalid", {31'b0, if_rvalid}, 32'd1);
        if (if_rvalid) check("if_rdata", {16'b0, if_rdata}, {16'b0, e.data});
      end else if (if_rvalid) begin
        check("if_rvalid_unexpected", {31'b0, if_rvalid}, 32'd0);
      end
      if (d_q.size() != 0 && d_q[0].due == cyc) begin
        exp_t e;
        e = d_q.pop_front();
        check("d_rvalid", {31'b0, d_rvalid}, 32'd1);
        if (d_rvalid) check("d_rdata", {16'b0, d_rdata}, {16'b0, e.data});
      end else if (d_rvalid) begin
        check("d_rvalid_unexpected", {31'b0, d_rvalid}, 32'd0);
      end
    end
  end

  // One request cycle: drive after the edge, check grants and RAM command at
  // the following negedge, and queue the expected read response if any.
  task automatic step(input logic ir, input logic [AW-1:0] ia,
                      input logic dr, input logic dw, input logic [AW-1:0] da,
                      input logic [DW-1:0] dwd,
                      input logic eig, input logic edg, input logic [DW-1:0] ed,
                      input logic push, input string name);
    @(posedge clk);
    #1;
    if_req  = ir;
    if_addr = ia;
    d_req   = dr;
    d_we    = dw;
    d_addr  = da;
    d_wdata = dwd;
    @(negedge clk);
    check({name, "_if_gnt"}, {31'b0, if_gnt}, {31'b0, eig});
    check({name, "_d_gnt"}, {31'b0, d_gnt}, {31'b0, edg});
    check({name, "_ram_ce"}, {31'b0, ram_ce}, {31'b0, eig | edg});
    check({name, "_ram_wre"}, {31'b0, ram_wre}, {31'b0, edg & dw});
    if (edg) check({name, "_ram_ad"}, {20'b0, ram_ad}, {20'b0, da});
    else if (eig) check({name, "_ram_ad"}, {20'b0, ram_ad}, {20'b0, ia});
    if (edg && dw) check({name, "_ram_din"}, {16'b0, ram_din}, {16'b0, dwd});
    if (push && eig) if_q.push_back('{due: cyc + 1, data: ed});
    if (push && edg && !dw) d_q.push_back('{due: cyc + 1, data: ed});
  endtask

  task automatic idle(input string name);
    step(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, name);
  endtask

  task automatic d_write(input logic [AW-1:0] a, input logic [DW-1:0] v);
    step(1'b0, '0, 1'b1, 1'b1, a, v, 1'b0, 1'b1, '0, 1'b0, "wr");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    if_req  = 1'b0;
    if_addr = '0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
    repeat (2) @(negedge clk);
    check("rst_if_rvalid", {31'b0, if_rvalid}, 32'd0);
    check("rst_d_rvalid", {31'b0, d_rvalid}, 32'd0);
    check("rst_ram_ce", {31'b0, ram_ce}, 32'd0);
    check("rst_ram_wre", {31'b0, ram_wre}, 32'd0);
    check("ram_oce", {31'b0, ram_oce}, 32'd1);
    check("ram_reset_hi", {31'b0, ram_reset}, 32'd1);
    reset = 1'b0;
    #1;
    check("ram_reset_lo", {31'b0, ram_reset}, 32'd0);

    // Preload through the data port.
    d_write(12'h000, 16'h3881);
    d_write(12'h010, 16'h1111);
    d_write(12'h011, 16'h2222);
    d_write(12'h012, 16'h3333);
    d_write(12'h005, 16'h0505);

    // Reset arrives before the granted read can return: no strobe ever.
    step(1'b0, '0, 1'b1, 1'b0, 12'h005, '0, 1'b0, 1'b1, '0, 1'b0, "rst_rd");
    reset = 1'b1;
    d_req = 1'b0;
    #1;
    check("rst_rd_d_rvalid_a", {31'b0, d_rvalid}, 32'd0);
    @(posedge clk);
    #1;
    check("rst_rd_d_rvalid_b", {31'b0, d_rvalid}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    idle("post_rst0");
    idle("post_rst1");

    // Single fetch.
    step(1'b1, 12'h000, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 16'h3881, 1'b1, "fetch");
    idle("fetch_done");

    // Write then read the same address on consecutive grants.
    step(1'b0, '0, 1'b1, 1'b1, 12'h123, 16'hBEEF, 1'b0, 1'b1, '0, 1'b0, "wr123");
    step(1'b0, '0, 1'b1, 1'b0, 12'h123, '0, 1'b0, 1'b1, 16'hBEEF, 1'b1, "rd123");
    idle("wr_rd_done");

    // Contention with STARVE_MAX=4: data wins 4 times, fetch 5th, data again.
    for (int i = 0; i < 4; i++)
      step(1'b1, 12'h000, 1'b1, 1'b0, 12'h010, '0, 1'b0, 1'b1, 16'h1111, 1'b1, "cont_d");
    step(1'b1, 12'h000, 1'b1, 1'b0, 12'h010, '0, 1'b1, 1'b0, 16'h3881, 1'b1, "cont_if");
    step(1'b1, 12'h000, 1'b1, 1'b0, 12'h010, '0, 1'b0, 1'b1, 16'h1111, 1'b1, "cont_d_again");
    idle("cont_done");

    // Back-to-back alternating requesters.
    step(1'b1, 12'h010, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 16'h1111, 1'b1, "b2b_if0");
    step(1'b0, '0, 1'b1, 1'b0, 12'h011, '0, 1'b0, 1'b1, 16'h2222, 1'b1, "b2b_d");
    step(1'b1, 12'h012, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 16'h3333, 1'b1, "b2b_if1");
    idle("b2b_drain");

    // Idle: no strobes, address holds the last driven value.
    for (int i = 0; i < 10; i++) begin
      idle("idle");
      check("idle_if_rvalid", {31'b0, if_rvalid}, 32'd0);
      check("idle_d_rvalid", {31'b0, d_rvalid}, 32'd0);
      check("idle_ram_ad_hold", {20'b0, ram_ad}, 32'h012);
    end

    check("if_q_empty", if_q.size(), 32'd0);
    check("d_q_empty", d_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mcu_ram_master.md
Name: mcu_ram_master

Overview:
- Initiator side of the MCU 4K x 16 single-port program/data RAM interface (ce/wre/ad/din/dout, 1-cycle registered read).
- Arbitrates two MCU requesters onto the single RAM port: the instruction-fetch port (read-only) and the data port (read/write).
- Returns read data to the requester with a one-cycle response strobe.
- Data accesses have priority; an anti-starvation counter guarantees fetch progress.

Parameters:
- ADDR_W, 12, RAM word-address width (4096 words)
- DATA_W, 16, RAM data width
- STARVE_MAX, 4, consecutive denied fetch cycles after which fetch gets priority (1..15)

Ports:
- clk  in  1  system clock, all logic rising-edge
- reset  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request, held until granted
- if_addr  in  ADDR_W  fetch word address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch data valid (cycle after grant)
- if_rdata  out  DATA_W  fetch data
- d_req  in  1  data request, held until granted
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data word address
- d_wdata  in  DATA_W  write data
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  data read valid (reads only)
- d_rdata  out  DATA_W  data read value
- ram_ce  out  1  RAM clock enable
- ram_oce  out  1  RAM output-register enable, constant 1
- ram_reset  out  1  RAM output reset, equals reset
- ram_wre  out  1  RAM write enable
- ram_ad  out  ADDR_W  RAM address
- ram_din  out  DATA_W  RAM write data
- ram_dout  in  DATA_W  RAM read data, valid one cycle after a ce read cycle

Behaviour:
- Reset (async, active-high) clears: if_rvalid=0, d_rvalid=0, prio state=PRIO_D, starve_cnt=0, resp_sel=none. Any in-flight read is dropped; no rvalid after reset release.
- Arbitration is combinational in the request cycle. Grant means ram_ce=1 in the same cycle with ram_ad, ram_wre, ram_din taken from the winner.
- No request: ram_ce=0, ram_wre=0, ram_ad/ram_din hold last driven values (registered mux select).
- Prio FSM:
  - PRIO_D: d_req wins over if_req.
  - PRIO_IF: if_req wins.
  - PRIO_D -> PRIO_IF when starve_cnt reaches STARVE_MAX.
  - PRIO_IF -> PRIO_D on the cycle if_gnt=1.
  - PRIO_IF with if_req=0 still grants d_req.
- starve_cnt: +1 each cycle (if_req & !if_gnt), saturates at STARVE_MAX; cleared on if_gnt or if_req=0.
- Only one grant per cycle; the loser sees gnt=0 and must hold its request fields stable.
- Read latency: a read granted in cycle N gives rvalid=1 for exactly cycle N+1 on the granted port's strobe. rdata = ram_dout (combinational pass-through) while rvalid=1. rdata is don't-care otherwise; the bench checks it only under rvalid.
- Writes: ram_wre=1 in the grant cycle; no response strobe. Write-then-read of the same address on consecutive grants returns the new data (the RAM's normal write mode handles this; no forwarding).
- Back-to-back: a grant every cycle is allowed; rvalid for cycle N and a new grant in N+1 coexist. resp_sel is a single register, updated every cycle from that cycle's grant.
- No response back-pressure: requesters must accept rvalid.
- ram_oce tied 1; ram_reset = reset.

Decomposition:
- Shared package mcu_mem_pkg holds:
  - ADDR_W/DATA_W defaults
  - prio state enum {PRIO_D, PRIO_IF}
  - resp_sel enum {RSP_NONE, RSP_IF, RSP_D}
- One natural sub-module, mcu_ram_arb: prio FSM + starve counter + grant logic. The top instantiates it and adds the RAM mux and response tracking.

Test Plan:
- Reset mid-read: d read addr 0x005 granted, reset asserted next cycle -> d_rvalid stays 0, state PRIO_D, starve_cnt 0.
- Single fetch: if_req addr 0x000 with preload 0x3881 -> if_gnt same cycle, if_rvalid next cycle, if_rdata=0x3881.
- Write/read: d write 0x123 data 0xBEEF, then d read 0x123 -> d_rvalid one cycle after read grant, d_rdata=0xBEEF; no rvalid for the write.
- Contention: if_req and d_req both held, continuous data reads, STARVE_MAX=4 -> d granted 4 cycles, fetch granted 5th cycle, then data again.
- Back-to-back alternating: fetch 0x010, data read 0x011, fetch 0x012 on consecutive cycles -> strobes alternate if/d/if on cycles +1..+3 with matching data.
- Idle: no requests for 10 cycles -> ram_ce=0, ram_wre=0, no rvalid.
